// File: rtl/gshare_predictor.sv
// gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational off current state; training comes from AGEX.
module gshare_predictor #(
  parameter int HIST_BITS    = 8,
  parameter int BTB_IDX_BITS = 4,
  parameter int DBITS        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DBITS-1:0]     fe_pc,
  output logic                 pred_taken,
  output logic [DBITS-1:0]     pred_target,
  output logic [HIST_BITS-1:0] pred_bhr,
  input  logic                 upd_valid,
  input  logic [DBITS-1:0]     upd_pc,
  input  logic                 upd_is_cond,
  input  logic                 upd_taken,
  input  logic [DBITS-1:0]     upd_target,
  input  logic [HIST_BITS-1:0] upd_bhr
);

  localparam int PHT_N = 1 << HIST_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

  logic [HIST_BITS-1:0] bhr_q, bhr_d;
  logic [1:0]           pht_q [PHT_N];
  logic                 btb_vld_q [BTB_N];
  logic                 btb_unc_q [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [DBITS-1:0]     btb_tgt_q [BTB_N];

  logic [BTB_IDX_BITS-1:0] lbi, ubi;
  logic [TAG_W-1:0]        ltag, utag;
  logic [HIST_BITS-1:0]    lpi, upi;
  logic                    hit;
  logic [1:0]              ctr, ctr_d;
  logic                    pht_we, btb_we;
  logic                    unused_pc_lsb;

  assign lbi  = fe_pc[BTB_IDX_BITS+1:2];
  assign ltag = fe_pc[DBITS-1:BTB_IDX_BITS+2];
  assign lpi  = fe_pc[HIST_BITS+1:2] ^ bhr_q;
  assign hit  = btb_vld_q[lbi] && (btb_tag_q[lbi] == ltag);

  assign pred_taken  = hit && (btb_unc_q[lbi] || pht_q[lpi][1]);
  assign pred_target = hit ? btb_tgt_q[lbi] : '0;
  assign pred_bhr    = bhr_q;

  assign ubi  = upd_pc[BTB_IDX_BITS+1:2];
  assign utag = upd_pc[DBITS-1:BTB_IDX_BITS+2];
  assign upi  = upd_pc[HIST_BITS+1:2] ^ upd_bhr;

  assign pht_we = upd_valid && upd_is_cond;
  assign btb_we = upd_valid && upd_taken;

  assign unused_pc_lsb = ^{fe_pc[1:0], upd_pc[1:0]};

  assign ctr = pht_q[upi];

  always_comb begin
    ctr_d = ctr;
    unique case (1'b1)
      upd_taken && (ctr != 2'b11):  ctr_d = ctr + 2'b01;
      !upd_taken && (ctr != 2'b00): ctr_d = ctr - 2'b01;
      default:                      ctr_d = ctr;
    endcase
  end

  // History is rebuilt from the carried snapshot, repairing wrong-path drift.
  always_comb begin
    bhr_d = bhr_q;
    if (pht_we) bhr_d = {upd_bhr[HIST_BITS-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bhr_q <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) btb_vld_q[i] <= 1'b0;
    end else begin
      bhr_q <= bhr_d;
      if (pht_we) pht_q[upi] <= ctr_d;
      if (btb_we) btb_vld_q[ubi] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_unc_q[ubi] <= ~upd_is_cond;
      btb_tag_q[ubi] <= utag;
      btb_tgt_q[ubi] <= upd_target;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboarded bench for gshare_predictor.
// Expected lookups are queued at drive time and popped at the negedge.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fe_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_bhr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_cond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [7:0]  upd_bhr = '0;

  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic [7:0]  bhr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  gshare_predictor #(
    .HIST_BITS(8), .BTB_IDX_BITS(4), .DBITS(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fe_pc(fe_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_bhr(pred_bhr), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_bhr(upd_bhr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic t, input logic [31:0] tg,
                      input logic [7:0] b);
    exp_t x;
    x.taken = t; x.tgt = tg; x.bhr = b;
    sb.push_back(x);
  endtask

  task automatic upd(input logic [31:0] pc, input logic c,
                     input logic t, input logic [31:0] tg,
                     input logic [7:0] b);
    upd_valid = 1'b1; upd_pc = pc; upd_is_cond = c;
    upd_taken = t; upd_target = tg; upd_bhr = b;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; fe_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    push(1'b0, 32'h0, 8'h00);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL reset_lookup got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
  endtask

  task automatic test_cond_train;
    upd(32'h100, 1'b1, 1'b1, 32'h140, 8'h00);
    fe_pc = 32'h100; push(1'b0, 32'h140, 8'h01);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL cond_first got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
    upd(32'h100, 1'b1, 1'b1, 32'h140, 8'h00);
    push(1'b0, 32'h140, 8'h01);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL cond_second got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
    upd(32'h404, 1'b1, 1'b1, 32'h444, 8'h01);
    fe_pc = 32'h100; push(1'b0, 32'h140, 8'h03);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL cond_bhr03 got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
  endtask

  task automatic test_jal;
    upd(32'h200, 1'b0, 1'b1, 32'h80, 8'h55);
    fe_pc = 32'h200; push(1'b1, 32'h80, 8'h03);
    fe_pc = 32'h100; push(1'b0, 32'h0, 8'h03);
    fe_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL jal_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
      fe_pc = 32'h100;
    end
  endtask

  task automatic test_same_cycle;
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_is_cond = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h380; upd_bhr = 8'h00;
    fe_pc = 32'h300;
    push(1'b0, 32'h0, 8'h03);
    push(1'b1, 32'h380, 8'h03);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL same_cycle_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
      @(posedge clk); #1; upd_valid = 1'b0;
    end
  endtask

  task automatic test_alias;
    upd(32'h104, 1'b0, 1'b1, 32'h500, 8'h00);
    push(1'b1, 32'h500, 8'h03);
    push(1'b0, 32'h0, 8'h03);
    fe_pc = 32'h104;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL alias_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
      fe_pc = 32'h144;
    end
  endtask

  task automatic test_not_taken_idle;
    upd(32'h10C, 1'b1, 1'b0, 32'h700, 8'h03);
    fe_pc = 32'h10C; push(1'b0, 32'h0, 8'h06);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL nt_no_btb got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
    upd_valid = 1'b0; upd_pc = 32'h10C; upd_is_cond = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h700; upd_bhr = 8'hAA;
    repeat (2) @(posedge clk);
    push(1'b0, 32'h0, 8'h06);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL idle_no_change got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
  endtask

  task automatic test_saturation;
    int ctr;
    upd(32'h108, 1'b1, 1'b1, 32'h600, 8'h00);
    ctr = 2;
    fe_pc = 32'h108;
    for (int i = 0; i < 5; i++) begin
      upd(32'h108, 1'b1, 1'b0, 32'h600, 8'h00);
      ctr = (ctr == 0) ? 0 : ctr - 1;
      push(ctr[1], 32'h600, 8'h00);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL sat_nt_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
    end
    ctr = 1;
    for (int i = 0; i < 5; i++) begin
      upd(32'h108, 1'b1, 1'b1, 32'h600, 8'hFF);
      ctr = (ctr == 3) ? 3 : ctr + 1;
      push(ctr[1], 32'h600, 8'hFF);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL sat_t_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] pcs [3];
    pcs[0] = 32'h108; pcs[1] = 32'h10C; pcs[2] = 32'h300;
    fe_pc = 32'h108;
    upd_valid = 1'b1; upd_pc = 32'h10C; upd_is_cond = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h700; upd_bhr = 8'h00;
    #2 reset_n = 1'b0;
    push(1'b0, 32'h0, 8'h00);
    #1;
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL reset_async got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
    repeat (2) @(posedge clk);
    #1 upd_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fe_pc = pcs[i];
      push(1'b0, 32'h0, 8'h00);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({pred_taken, pred_target, pred_bhr} !== e) begin
        failures++;
        $display("FAIL reset_lost_%0d got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
          i, pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
      end
    end
    upd(32'h108, 1'b1, 1'b1, 32'h600, 8'h7F);
    fe_pc = 32'h108; push(1'b0, 32'h600, 8'hFF);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL reset_pht got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
  endtask

  initial begin
    test_reset();
    test_cond_train();
    test_jal();
    test_same_cycle();
    test_alias();
    test_not_taken_idle();
    test_saturation();
    fe_pc = 32'h108; push(1'b1, 32'h600, 8'hFF);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if ({pred_taken, pred_target, pred_bhr} !== e) begin
      failures++;
      $display("FAIL pre_reset got t=%b tg=%h b=%h exp t=%b tg=%h b=%h",
        pred_taken, pred_target, pred_bhr, e.taken, e.tgt, e.bhr);
    end
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Direction and target predictor sitting beside the fetch stage: fetch presents its PC and receives a taken/target prediction in the same cycle.
- Resolved control-flow outcomes arrive from the execute (AGEX) stage one cycle after resolution. They train a gshare pattern history table (PHT), a global history register (BHR) and a direct-mapped branch target buffer (BTB).
- Replaces the simple predictor slot in the pipeline top level; all state is internal.

Parameters:
- HIST_BITS, 8: BHR width; also the PHT index width (PHT has 2^HIST_BITS entries).
- BTB_IDX_BITS, 4: BTB has 2^BTB_IDX_BITS entries, indexed by pc[BTB_IDX_BITS+1:2].
- DBITS, 32: PC and target width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fe_pc  in  DBITS  PC being fetched this cycle.
- pred_taken  out  1  1 means redirect fetch to pred_target.
- pred_target  out  DBITS  predicted target; 0 when BTB misses.
- pred_bhr  out  HIST_BITS  BHR snapshot used for this lookup; the pipeline carries it down to AGEX.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  DBITS  PC of the resolved instruction.
- upd_is_cond  in  1  1 for a conditional branch, 0 for jal/jalr.
- upd_taken  in  1  actual direction; jal/jalr always drive 1.
- upd_target  in  DBITS  actual taken target.
- upd_bhr  in  HIST_BITS  pred_bhr snapshot carried with the instruction.

Behaviour:
- Lookup is purely combinational from current state; zero-cycle latency.
  - BTB index bi = fe_pc[BTB_IDX_BITS+1:2]; tag = fe_pc[DBITS-1:BTB_IDX_BITS+2].
  - hit = btb_valid[bi] and tag match.
  - PHT index pi = fe_pc[HIST_BITS+1:2] XOR bhr.
  - pred_taken = hit AND (btb_uncond[bi] OR pht[pi][1]).
  - pred_target = btb_target[bi] when hit, else 0.
  - pred_bhr = bhr.
- Update happens on the rising edge when upd_valid=1.
  - BTB: when upd_taken=1, write valid=1, the tag, target=upd_target and uncond=~upd_is_cond into entry upd_pc[BTB_IDX_BITS+1:2], replacing any previous entry. When upd_taken=0, the BTB is untouched.
  - Conditional (upd_is_cond=1), PHT: index = upd_pc[HIST_BITS+1:2] XOR upd_bhr, using the snapshot, not the live bhr. The 2-bit counter increments when taken and decrements when not taken, saturating at 3 and 0.
  - Conditional, BHR: bhr <= {upd_bhr[HIST_BITS-2:0], upd_taken}. Rebuilding from the snapshot repairs history after wrong-path updates.
  - Unconditional (upd_is_cond=0): PHT and BHR are unchanged.
- The BHR is non-speculative: it changes only on updates, never on lookups.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update value. There is no bypass; the new value is visible from the next cycle.
- upd_valid=0: no state changes.
- Reset (async assert, any time, including mid-update) sets:
  - bhr = 0;
  - every PHT counter = 2'b01 (weakly not-taken);
  - every BTB valid = 0.
  - BTB target, tag and uncond contents are don't-care.
  - Outputs during reset: pred_taken=0, pred_target=0, pred_bhr=0.
- Release is synchronous to the design's reset synchronizer. The first edge after deassertion may accept an update.
- PC bits [1:0] are ignored everywhere.

Test Plan:
- Reset then lookup fe_pc=0x100 -> pred_taken=0, pred_target=0, pred_bhr=0x00.
- Conditional branch upd_pc=0x100, taken, target 0x140, upd_bhr=0x00, applied twice -> bhr after first update 0x01; PHT[0x40^0x00] goes 01->10 then 10->11. Lookup 0x100 with bhr=0x03 indexes PHT[0x43]=01 -> pred_taken=0, pred_target=0x140 (BTB hit, counter not-taken).
- jal upd_pc=0x200, is_cond=0, taken, target 0x80 -> next cycle fe_pc=0x200 gives pred_taken=1, pred_target=0x80; bhr unchanged.
- Same-cycle fe_pc=0x300 and first update to 0x300 -> that cycle pred_target=0 and miss; the following cycle hits.
- Saturation: 5 not-taken updates on one PHT entry -> counter 00, no wrap to 11; 5 taken -> 11, no wrap to 00.
- BTB aliasing: train 0x104 taken to 0x500, then lookup 0x144 (same index, different tag) -> miss, pred_taken=0.
- Assert reset_n=0 mid-sequence, asynchronously between edges -> outputs go to 0 immediately; all prior training is lost on the subsequent lookup.
